// File: rtl/eclair_pkg.sv
// eclair_pkg: shared control-store widths and loader state encoding.
package eclair_pkg;
  localparam int CS_ADDR_WIDTH = 8;
  localparam int CS_DATA_WIDTH = 64;
  typedef enum logic [2:0] {IDLE, CP_ADDR, CP_WRITE, VF_ADDR, VF_CMP, DONE} cs_state_t;
endpackage

// File: rtl/cs_loader_counter.sv
// cs_loader_counter: address counter with synchronous preset load and count enable.
module cs_loader_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= preset;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/cs_loader.sv
// cs_loader: copies microcode EPROM into control store RAM at 2 cycles/word.
// Define CS_LOADER_VERIFY_EN to add a read-back verify pass with a sticky error flag.
module cs_loader
  import eclair_pkg::*;
#(
  parameter int ADDR_WIDTH = CS_ADDR_WIDTH,
  parameter int DATA_WIDTH = CS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram__w,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  ready,
  output logic                  error
);
`ifdef CS_LOADER_VERIFY_EN
  localparam cs_state_t COPY_END = VF_ADDR;
`else
  localparam cs_state_t COPY_END = DONE;
`endif
  cs_state_t state, next;
  logic [ADDR_WIDTH-1:0] addr;
  logic last, load, en;
  assign last = &addr;
  assign load = state == IDLE || (state == DONE && reload);
  assign en = state == CP_WRITE || state == VF_CMP;
  assign rom_addr = addr;
  assign ram_addr = addr;
  cs_loader_counter #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(clk),
    .reset(reset),
    .load(load),
    .preset({ADDR_WIDTH{1'b0}}),
    .en(en),
    .count(addr)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = CP_ADDR;
      CP_ADDR:  next = CP_WRITE;
      CP_WRITE: next = last ? COPY_END : CP_ADDR;
      VF_ADDR:  next = VF_CMP;
      VF_CMP:   next = last ? DONE : VF_ADDR;
      DONE:     next = reload ? CP_ADDR : DONE;
      default:  next = IDLE;
    endcase
  end
  // Strobes and status are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ram_wdata <= '0;
      ram__w    <= 1'b1;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state <= next;
      if (state == CP_ADDR) ram_wdata <= rom_data;
      ram__w <= next != CP_WRITE;
      busy   <= next != IDLE && next != DONE;
      ready  <= next == DONE;
    end
`ifdef CS_LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) error <= 1'b0;
    else if (state == DONE && reload) error <= 1'b0;
    else if (state == VF_CMP && ram_rdata != rom_data) error <= 1'b1;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_cs_loader.sv
// tb_cs_loader: random-content EPROM/RAM models checking the control store loader.
module tb_cs_loader;
`ifdef CS_LOADER_VERIFY_EN
  localparam int LAT = 1024;
  localparam bit VF = 1'b1;
`else
  localparam int LAT = 512;
  localparam bit VF = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, reload = 1'b0;
  logic [7:0] rom_addr, ram_addr;
  logic [63:0] rom_data, ram_rdata, ram_wdata;
  logic ram__w, busy, ready, error;
  logic [63:0] rom [256];
  logic [63:0] mem [256];
  bit corrupt = 1'b0;
  int total = 0, bad = 0;

  cs_loader dut (
    .clk(clk), .reset(reset), .reload(reload),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram__w(ram__w),
    .ram_rdata(ram_rdata), .busy(busy), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  assign ram_rdata = mem[ram_addr] ^ ((corrupt && ram_addr == 8'h42) ? 64'h8000_0000_0000_0000 : 64'h0);
  always @(negedge clk) if (ram__w === 1'b0) mem[ram_addr] <= ram_wdata;

  task automatic fill_rom(input bit pattern);
    for (int n = 0; n < 256; n++) rom[n] = pattern ? {56'h0, 8'(n)} : {$urandom, $urandom};
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || error !== 1'b0 || ram__w !== 1'b1 ||
        rom_addr !== 8'h00 || ram_addr !== 8'h00 || ram_wdata !== 64'h0) begin
      bad++;
      $display("FAIL %s: busy=%b ready=%b error=%b ram__w=%b rom_addr=%h ram_addr=%h wdata=%h expected 0 0 0 1 00 00 0",
               tag, busy, ready, error, ram__w, rom_addr, ram_addr, ram_wdata);
    end
  endtask

  // One full load observed cycle by cycle; optionally reload from DONE first,
  // pulse reload at a copy address, or abort with reset at a copy address.
  task automatic run_load(input bit do_reload, input int abort_addr, input int reload_addr, input string tag);
    int cyc, np, errs;
    bit started, prev_low, done;
    for (int n = 0; n < 256; n++) mem[n] = {$urandom, $urandom};
    cyc = 0; np = 0; started = 0; prev_low = 0; done = 0;
    if (do_reload) reload = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      reload = 1'b0;
      if (!started) begin
        if (busy === 1'b1) begin
          started = 1;
          total++;
          if (ready !== 1'b0 || error !== 1'b0 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL %s start: ready=%b error=%b addr=%h expected 0 0 00", tag, ready, error, rom_addr);
          end
        end
      end else cyc++;
      if (ram__w === 1'b0) begin
        total++;
        if (prev_low || np > 255 || ram_addr !== np[7:0] || rom_addr !== ram_addr || ram_wdata !== rom[np[7:0]]) begin
          bad++;
          $display("FAIL %s pulse %0d: addr=%h wdata=%h prev_low=%b expected addr=%h wdata=%h",
                   tag, np, ram_addr, ram_wdata, prev_low, np[7:0], rom[np[7:0]]);
        end
        if (reload_addr == np) reload = 1'b1;
        if (abort_addr == np) begin
          reset = 1'b1;
          #1;
          check_idle({tag, " async reset"});
          repeat (2) @(posedge clk);
          #1;
          check_idle({tag, " held reset"});
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        @(negedge clk);
        total++;
        if (ram__w !== 1'b0 || ram_addr !== np[7:0] || ram_wdata !== rom[np[7:0]]) begin
          bad++;
          $display("FAIL %s pulse %0d stable: ram__w=%b addr=%h wdata=%h", tag, np, ram__w, ram_addr, ram_wdata);
        end
        np++;
        prev_low = 1;
      end else prev_low = 0;
      if (ready === 1'b1) done = 1;
    end
    total++;
    if (!done || cyc != LAT) begin
      bad++;
      $display("FAIL %s latency: done=%b cycles=%0d expected %0d", tag, done, cyc, LAT);
    end
    total++;
    if (np != 256) begin
      bad++;
      $display("FAIL %s pulse count: got %0d expected 256", tag, np);
    end
    errs = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== rom[n]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s ram contents: wrong words=%0d expected 0", tag, errs);
    end
    total++;
    if (busy !== 1'b0 || error !== (VF && corrupt)) begin
      bad++;
      $display("FAIL %s done flags: busy=%b error=%b expected 0 %b", tag, busy, error, VF && corrupt);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_copy;
    fill_rom(1'b1);
    run_load(1'b0, -1, -1, "copy");
  endtask

  task automatic test_reload;
    fill_rom(1'b0);
    run_load(1'b1, -1, 16, "reload");
  endtask

  task automatic test_mid_reset;
    fill_rom(1'b0);
    run_load(1'b1, 128, -1, "abort");
    run_load(1'b0, -1, -1, "restart");
  endtask

  task automatic test_corrupt;
    fill_rom(1'b0);
    corrupt = 1'b1;
    run_load(1'b1, -1, -1, "corrupt");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (error !== 1'b1 || ready !== 1'b1) begin
        bad++;
        $display("FAIL corrupt sticky: error=%b ready=%b expected 1 1", error, ready);
      end
    end
    corrupt = 1'b0;
    run_load(1'b1, -1, -1, "clean");
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      fill_rom(1'b0);
      run_load(1'b1, -1, -1, "b2b");
    end
  endtask

  initial begin
    test_reset;
    test_copy;
    test_reload;
    test_mid_reset;
`ifdef CS_LOADER_VERIFY_EN
    test_corrupt;
`endif
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cs_loader.md
CS_LOADER -- requirements
Module: cs_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, control store address width (256 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, microcode word width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port reload  input  1  request a fresh copy; sampled only in DONE.
REQ-006 SHALL have port rom_addr  output  ADDR_WIDTH  microcode EPROM address.
REQ-007 SHALL have port rom_data  input  DATA_WIDTH  EPROM read data, valid 1 cycle after rom_addr.
REQ-008 SHALL have port ram_addr  output  ADDR_WIDTH  control store RAM address, equal to rom_addr while busy.
REQ-009 SHALL have port ram_wdata  output  DATA_WIDTH  word written to control store RAM.
REQ-010 SHALL have port ram__w  output  1  RAM write strobe, active-low, registered.
REQ-011 SHALL have port ram_rdata  input  DATA_WIDTH  RAM read data for verify pass.
REQ-012 SHALL have port busy  output  1  copy or verify in progress.
REQ-013 SHALL have port ready  output  1  control store loaded; CPU may run from RAM.
REQ-014 SHALL have port error  output  1  sticky verify mismatch flag.

Function
REQ-015 SHALL implement states IDLE, CP_ADDR, CP_WRITE, VF_ADDR, VF_CMP, DONE.
REQ-016 SHALL leave IDLE to CP_ADDR on the first clk edge after reset deasserts, address 0, busy=1.
REQ-017 CP_ADDR SHALL drive address for one cycle and capture rom_data into ram_wdata at its end.
REQ-018 CP_WRITE SHALL hold ram__w=0 for exactly one cycle with ram_addr and ram_wdata stable the whole cycle, then increment the address.
REQ-019 Copy SHALL take 2 cycles per word, 512 cycles for 256 words; ram__w SHALL be 1 in every state other than CP_WRITE.
REQ-020 After writing address 255 the address SHALL wrap to 0 and enter VF_ADDR (verify built) or DONE (not built).
REQ-021 VF_CMP SHALL compare ram_rdata with rom_data; mismatch SHALL set error; address 255 compared SHALL go to DONE.
REQ-022 DONE SHALL assert ready=1, busy=0; ready SHALL assert even when error=1.
REQ-023 reload=1 in DONE SHALL clear ready and error, zero the address and enter CP_ADDR next cycle; reload in other states SHALL be ignored.
REQ-024 Outputs SHALL be registered; no combinational path from inputs to ram__w, ready, busy.

Reset
REQ-025 Reset at any time, including mid-copy or mid-verify, SHALL force IDLE, address 0, ram_wdata 0, ram__w=1, busy=0, ready=0, error=0 immediately.
REQ-026 A partially written control store after mid-operation reset SHALL be fully rewritten on restart from address 0.

Configuration
REQ-027 Macro CS_LOADER_VERIFY_EN SHALL compile in the VF_ADDR/VF_CMP read-back pass (ready after 1024 cycles).
REQ-028 Without CS_LOADER_VERIFY_EN, error SHALL be tied 0, ram_rdata ignored, ready after 512 cycles; ports unchanged.

Structure
REQ-029 Shared package eclair_pkg SHALL hold CS_ADDR_WIDTH=8, CS_DATA_WIDTH=64 and the loader state enum.
REQ-030 Address generation SHALL use the existing counter sub-module (WIDTH=ADDR_WIDTH, load/preset for reload clear).

Verification
REQ-031 Reset 3 cycles then release, ROM word n = {56'h0, n} -> RAM word n matches for n=0..255; ready rises cycle 512 (1024 with verify).
REQ-032 Count ram__w low pulses during one load -> exactly 256, each 1 cycle, addresses 0x00..0xFF in order, ram_wdata stable across each pulse.
REQ-033 Assert reset at copy address 0x80 for 2 cycles -> all outputs at reset values at once; restart copies from 0x00, all 256 words correct.
REQ-034 Verify built, RAM model corrupts word 0x42 bit 63 -> error=1 and ready=1 at cycle 1024; error stays 1 until reload.
REQ-035 Pulse reload during CP_WRITE at 0x10 -> ignored; pulse reload in DONE -> ready=0, error=0 next cycle, full copy repeats.
